// File: rtl/reset_sequencer_if.sv
// Board-side reset sources and the clean core reset, bundled between the board glue
// (master) and the reset sequencer (slave).
interface reset_sequencer_if;
  logic       key_n;
  logic       plug_resn;
  logic       pll_locked;
  logic       core_res;
  logic [1:0] res_cause;
  logic       key_pressed;

  modport master (
    output key_n,
    output plug_resn,
    output pll_locked,
    input  core_res,
    input  res_cause,
    input  key_pressed
  );

  modport slave (
    input  key_n,
    input  plug_resn,
    input  pll_locked,
    output core_res,
    output res_cause,
    output key_pressed
  );
endinterface

// File: rtl/reset_sequencer.sv
// Reset front-end for the Propeller core: synchronises the board reset sources,
// debounces the button, and stretches the result into one clean core reset.
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8000000,
  parameter int PULSE_CYCLES    = 8000000
) (
  input  logic              clock,
  input  logic              res,
  reset_sequencer_if.slave  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(PULSE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STRETCH_LAST = SW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_KEY  = 2'd1;
  localparam logic [1:0] CAUSE_PLUG = 2'd2;
  localparam logic [1:0] CAUSE_LOCK = 2'd3;

  logic [SYNC_STAGES-1:0] key_sync;
  logic [SYNC_STAGES-1:0] plug_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   key_s;
  logic                   plug_s;
  logic                   lock_s;

  logic [DW-1:0] deb_cnt;
  logic          key_pressed;
  logic          key_differs;

  state_t        state;
  logic [SW-1:0] stretch_cnt;
  logic          core_res;
  logic [1:0]    res_cause;
  logic          src;

  // Synchronisers reset to the idle level of each pin so a block reset never
  // looks like a fresh reset request from the board.
  always_ff @(posedge clock) begin
    if (res) begin
      key_sync  <= '1;
      plug_sync <= '1;
      lock_sync <= '0;
    end else begin
      key_sync  <= {key_sync[SYNC_STAGES-2:0],  bus.key_n};
      plug_sync <= {plug_sync[SYNC_STAGES-2:0], bus.plug_resn};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.pll_locked};
    end
  end

  assign key_s  = key_sync[SYNC_STAGES-1];
  assign plug_s = plug_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];

  // key_s is active-low, so the button disagrees with the debounced state
  // exactly when the two levels are equal.
  assign key_differs = (key_s == key_pressed);

  always_ff @(posedge clock) begin
    if (res) begin
      deb_cnt     <= '0;
      key_pressed <= 1'b0;
    end else if (!key_differs) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt     <= '0;
      key_pressed <= ~key_pressed;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign src = key_pressed | ~plug_s | ~lock_s;

  // The cause is latched only when a running core gets knocked back into reset;
  // re-triggers while already in reset keep the original cause.
  always_ff @(posedge clock) begin
    if (res) begin
      state       <= HOLD;
      stretch_cnt <= '0;
      core_res    <= 1'b1;
      res_cause   <= CAUSE_NONE;
    end else begin
      unique case (state)
        HOLD: begin
          stretch_cnt <= '0;
          core_res    <= 1'b1;
          if (!src) begin
            state <= STRETCH;
          end
        end
        STRETCH: begin
          if (src) begin
            state       <= HOLD;
            stretch_cnt <= '0;
            core_res    <= 1'b1;
          end else if (stretch_cnt == STRETCH_LAST) begin
            state       <= RUN;
            stretch_cnt <= '0;
            core_res    <= 1'b0;
          end else begin
            stretch_cnt <= stretch_cnt + 1'b1;
            core_res    <= 1'b1;
          end
        end
        RUN: begin
          stretch_cnt <= '0;
          if (src) begin
            state    <= HOLD;
            core_res <= 1'b1;
            if (!lock_s) begin
              res_cause <= CAUSE_LOCK;
            end else if (!plug_s) begin
              res_cause <= CAUSE_PLUG;
            end else begin
              res_cause <= CAUSE_KEY;
            end
          end else begin
            core_res <= 1'b0;
          end
        end
        default: begin
          state       <= HOLD;
          stretch_cnt <= '0;
          core_res    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.core_res    = core_res;
  assign bus.res_cause   = res_cause;
  assign bus.key_pressed = key_pressed;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Reset front-end between the board reset sources and the Propeller core's `inp_res` input.
- Synchronises and debounces the push-button, and synchronises the Prop-plug RESn pin and the PLL lock.
- Produces one clean, minimum-width, active-high core reset in the fixed 160 MHz clock domain, plus a sticky record of the reset cause.

Parameters:
- SYNC_STAGES, 2: flops in each async-input synchroniser (min 2).
- DEBOUNCE_CYCLES, 8000000: consecutive stable cycles for the button to change its debounced state (50 ms @160 MHz).
- PULSE_CYCLES, 8000000: minimum core_res hold time after all sources release.

Ports:
- clock  in  1  160 MHz system clock; all logic on rising edge.
- res  in  1  synchronous, active-high block reset.
- key_n  in  1  async push-button, low = pressed.
- plug_resn  in  1  async Prop-plug reset, low = reset; not debounced.
- pll_locked  in  1  async PLL lock, low = unlocked.
- core_res  out  1  registered active-high reset to the core.
- res_cause  out  2  last cause of a run-time reset: 0 = block reset/power-on, 1 = key, 2 = plug, 3 = lock loss.
- key_pressed  out  1  debounced button state, high = pressed.

Behaviour:

Reset (`res` = 1 at an edge):
- All synchroniser flops go to the idle level: key_n 1, plug_resn 1, pll_locked 0.
- Debounce counter = 0; key_pressed = 0.
- FSM = HOLD; stretch counter = 0; core_res = 1; res_cause = 0.
- `res` wins over every other event on the same edge.

Synchronisers:
- SYNC_STAGES-deep flop chain per input.
- Internal signals:
  - key_s: synchronised key_n.
  - plug_s: synchronised plug_resn.
  - lock_s: synchronised pll_locked.

Debounce:
- The counter increments while key_s differs from ~key_pressed.
- The counter clears whenever they match.
- When the counter reaches DEBOUNCE_CYCLES-1 while still differing, key_pressed toggles on that edge and the counter clears.
- Glitches shorter than DEBOUNCE_CYCLES cycles never change key_pressed.

Reset request:
- src = key_pressed | ~plug_s | ~lock_s (combinational).

FSM (core_res registered; high in HOLD and STRETCH, low only in RUN):
- HOLD:
  - src = 1: stay.
  - src = 0: go to STRETCH, stretch counter := 0.
- STRETCH:
  - src = 1: go to HOLD.
  - Else, counter = PULSE_CYCLES-1: go to RUN.
  - Else: counter + 1.
- RUN:
  - src = 1: go to HOLD. core_res is 1 after that edge.
  - On this transition, res_cause := 3 if ~lock_s, else 2 if ~plug_s, else 1 (priority lock > plug > key).
- res_cause changes only on the RUN→HOLD transition or on `res`. A re-trigger during STRETCH does not update it.

Latency and widths:
- Plug or lock assertion reaches core_res after exactly SYNC_STAGES+1 edges, counting from the first edge that samples the pin active.
- Key assertion adds DEBOUNCE_CYCLES cycles to that.
- After the last source releases, core_res stays high for exactly PULSE_CYCLES cycles plus the synchroniser (and, for the key, debounce) latency.
- Counter widths are $clog2(N+1). Counters never wrap: they saturate or clear as described.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PULSE_CYCLES=8):
1. Power-up:
   - Stimulus: res=1 for 3 cycles, pll_locked=1, key_n=1, plug_resn=1.
   - Required: core_res=1 throughout `res`.
   - Required: core_res=1 for a further 2 (sync)+1+8 cycles, then 0.
   - Required: res_cause=0 and key_pressed=0 throughout.
2. Key glitch vs. press, in RUN:
   - Stimulus: key_n low for 3 cycles.
   - Required: key_pressed and core_res unchanged.
   - Stimulus: key_n low for 20 cycles.
   - Required: key_pressed=1 and core_res=1 exactly 2+4+1 edges after the first low sample; res_cause=1.
   - Required after release: core_res returns to 0 only after 2+4+8+1 more cycles.
3. Plug reset, in RUN:
   - Stimulus: plug_resn low for 1 cycle.
   - Required: core_res=1 on the 3rd edge; res_cause=2; core_res held for 9 cycles after plug_s returns high.
4. Re-trigger during STRETCH:
   - Stimulus: after a key reset, drop pll_locked for 1 cycle when the stretch counter = 5.
   - Required: FSM returns to HOLD; a full 8-cycle stretch restarts; res_cause stays 1.
5. Simultaneous sources:
   - Stimulus: plug_resn and pll_locked fall on the same cycle, in RUN.
   - Required: res_cause=3.
   - Stimulus: plug_resn and a key press arrive so both are visible on the same edge.
   - Required: res_cause=2.
6. Reset mid-operation:
   - Stimulus: assert res during RUN and during STRETCH.
   - Required: next edge core_res=1, res_cause=0, key_pressed=0, counters=0.
   - Required: synchroniser outputs are at the idle levels on the edge after res deasserts.
